// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel rise/fall detection with one
// pending slot per edge type, merged into a single valid/ready event port by round robin.
module edge_event_arbiter #(
  parameter int NCH = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] sig_in,
  input  logic [NCH-1:0] pos_en,
  input  logic [NCH-1:0] neg_en,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_ch,
  output logic           evt_pos,
  output logic [NCH-1:0] ovf,
  input  logic           ovf_clr
);

  // Handshake: an event transfers on a cycle where evt_valid && evt_ready are
  // both high; while evt_valid && !evt_ready, evt_ch/evt_pos are held stable.

  logic [NCH-1:0] s1, s2;
  logic [NCH-1:0] pp, pn, old;
  logic [IDW-1:0] ptr;

  logic [NCH-1:0] rise, fall;
  logic [NCH-1:0] pend_any;
  logic           load;
  logic           sel_found;
  logic [IDW-1:0] sel_ch;
  logic           sel_pos;
  logic [IDW-1:0] ptr_nx;
  logic [NCH-1:0] sel_oh;
  logic [NCH-1:0] clr_pp, clr_pn;
  logic [NCH-1:0] pp_keep, pn_keep;
  logic [NCH-1:0] pp_nx, pn_nx, old_nx, ovf_nx, ovf_set;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NCH) s = s - NCH;
    return IDW'(s);
  endfunction

  assign rise     = s1 & ~s2 & pos_en;
  assign fall     = ~s1 & s2 & neg_en;
  assign pend_any = pp | pn;
  assign load     = !evt_valid || evt_ready;

  // Round-robin scan starting at ptr; first channel with anything pending wins.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!sel_found && pend_any[wrap_add(ptr, k)]) begin
        sel_found = 1'b1;
        sel_ch    = wrap_add(ptr, k);
      end
    end
  end

  // old[i] = 1 means the pending rise is older than the pending fall.
  always_comb begin
    sel_pos = 1'b0;
    if (sel_found) begin
      if (pp[sel_ch] && pn[sel_ch]) sel_pos = old[sel_ch];
      else                          sel_pos = pp[sel_ch];
    end
  end

  assign ptr_nx = (sel_ch == IDW'(NCH - 1)) ? '0 : sel_ch + 1'b1;

  always_comb begin
    sel_oh = '0;
    clr_pp = '0;
    clr_pn = '0;
    if (load && sel_found) begin
      sel_oh[sel_ch] = 1'b1;
      if (sel_pos) clr_pp = sel_oh;
      else         clr_pn = sel_oh;
    end
  end

  assign pp_keep = pp & ~clr_pp;
  assign pn_keep = pn & ~clr_pn;
  assign pp_nx   = pp_keep | rise;
  assign pn_nx   = pn_keep | fall;

  // An edge landing on a slot that is being drained this cycle is not a loss.
  assign ovf_set = (rise & pp_keep) | (fall & pn_keep);
  assign ovf_nx  = (ovf & ~{NCH{ovf_clr}}) | ovf_set;

  // Order only changes on a fresh entry; merging into an existing slot keeps its age.
  always_comb begin
    old_nx = old;
    for (int i = 0; i < NCH; i++) begin
      if (rise[i] && pn_keep[i] && !pp_keep[i])
        old_nx[i] = 1'b0;
      else if (fall[i] && pp_keep[i] && !pn_keep[i])
        old_nx[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= sig_in;
      s2        <= sig_in;
      pp        <= '0;
      pn        <= '0;
      old       <= '0;
      ovf       <= '0;
      ptr       <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_pos   <= 1'b0;
    end else begin
      s1  <= sig_in;
      s2  <= s1;
      pp  <= pp_nx;
      pn  <= pn_nx;
      old <= old_nx;
      ovf <= ovf_nx;
      if (load) begin
        if (sel_found) begin
          evt_valid <= 1'b1;
          evt_ch    <= sel_ch;
          evt_pos   <= sel_pos;
          ptr       <= ptr_nx;
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: reset, latency, round robin, stall/overflow,
// enables and mid-operation reset, each checked against hand-derived values.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] sig_in;
  logic [3:0] pos_en;
  logic [3:0] neg_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_pos;
  logic [3:0] ovf;
  logic       ovf_clr;

  int checks;
  int failures;

  edge_event_arbiter #(.NCH(4), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .pos_en    (pos_en),
    .neg_en    (neg_en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_pos   (evt_pos),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Change levels with detection disabled so the transition produces no event.
  task automatic quiet_set(input logic [3:0] v);
    pos_en = 4'b0000;
    neg_en = 4'b0000;
    sig_in = v;
    repeat (3) step();
    pos_en = 4'b1111;
    neg_en = 4'b1111;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sig_in = 4'b0101;
    step();
    step();
    checks++;
    if (evt_valid !== 1'b0 || evt_ch !== 2'd0 || evt_pos !== 1'b0 || ovf !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state: got v=%b ch=%0d pos=%b ovf=%b, expected v=0 ch=0 pos=0 ovf=0000",
               evt_valid, evt_ch, evt_pos, ovf);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_release_idle cycle %0d: got evt_valid=%b, expected 0", i, evt_valid);
      end
    end
    checks++;
    if (ovf !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release_ovf: got %b, expected 0000", ovf);
    end
  endtask

  task automatic test_latency();
    quiet_set(4'b0000);
    for (int e = 0; e < 2; e++) begin
      logic exp_pos;
      exp_pos = (e == 0);
      sig_in[2] = exp_pos;
      for (int c = 1; c <= 4; c++) begin
        step();
        checks++;
        if (c == 3) begin
          if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_pos !== exp_pos) begin
            failures++;
            $display("FAIL latency_event e=%0d: got v=%b ch=%0d pos=%b, expected v=1 ch=2 pos=%b",
                     e, evt_valid, evt_ch, evt_pos, exp_pos);
          end
        end else if (evt_valid !== 1'b0) begin
          failures++;
          $display("FAIL latency_idle e=%0d cycle %0d: got evt_valid=%b, expected 0", e, c, evt_valid);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int b = 0; b < 2; b++) begin
      logic exp_pos;
      exp_pos = (b == 0);
      sig_in = exp_pos ? 4'b1111 : 4'b0000;
      step();
      step();
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'(c) || evt_pos !== exp_pos) begin
          failures++;
          $display("FAIL rr_order burst=%0d slot=%0d: got v=%b ch=%0d pos=%b, expected v=1 ch=%0d pos=%b",
                   b, c, evt_valid, evt_ch, evt_pos, c, exp_pos);
        end
      end
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL rr_drained burst=%0d: got evt_valid=%b, expected 0", b, evt_valid);
      end
    end
  endtask

  task automatic test_stall_overflow();
    evt_ready = 1'b0;
    sig_in[0] = 1'b1;
    repeat (3) step();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_pos !== 1'b1) begin
      failures++;
      $display("FAIL stall_first: got v=%b ch=%0d pos=%b, expected v=1 ch=0 pos=1",
               evt_valid, evt_ch, evt_pos);
    end
    sig_in[1] = 1'b1;
    repeat (2) step();
    sig_in[1] = 1'b0;
    repeat (2) step();
    sig_in[1] = 1'b1;
    repeat (2) step();
    checks++;
    if (ovf !== 4'b0010) begin
      failures++;
      $display("FAIL ovf_set: got %b, expected 0010", ovf);
    end
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_pos !== 1'b1) begin
      failures++;
      $display("FAIL stall_hold: got v=%b ch=%0d pos=%b, expected v=1 ch=0 pos=1",
               evt_valid, evt_ch, evt_pos);
    end
    evt_ready = 1'b1;
    step();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pos !== 1'b1) begin
      failures++;
      $display("FAIL order_rise_first: got v=%b ch=%0d pos=%b, expected v=1 ch=1 pos=1",
               evt_valid, evt_ch, evt_pos);
    end
    step();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pos !== 1'b0) begin
      failures++;
      $display("FAIL order_fall_second: got v=%b ch=%0d pos=%b, expected v=1 ch=1 pos=0",
               evt_valid, evt_ch, evt_pos);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL no_third_event cycle %0d: got evt_valid=%b, expected 0", c, evt_valid);
      end
    end
    checks++;
    if (ovf !== 4'b0010) begin
      failures++;
      $display("FAIL ovf_sticky: got %b, expected 0010", ovf);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 4'b0000) begin
      failures++;
      $display("FAIL ovf_clear: got %b, expected 0000", ovf);
    end
  endtask

  task automatic test_enables();
    pos_en[3] = 1'b0;
    sig_in[3] = 1'b1;
    step();
    step();
    sig_in[3] = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      step();
      checks++;
      if (c == 5) begin
        if (evt_valid !== 1'b1 || evt_ch !== 2'd3 || evt_pos !== 1'b0) begin
          failures++;
          $display("FAIL enable_fall_only: got v=%b ch=%0d pos=%b, expected v=1 ch=3 pos=0",
                   evt_valid, evt_ch, evt_pos);
        end
      end else if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL enable_suppressed cycle %0d: got evt_valid=%b, expected 0", c, evt_valid);
      end
    end
    pos_en[3] = 1'b1;
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    sig_in = 4'b1110;
    repeat (3) step();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_pos !== 1'b0) begin
      failures++;
      $display("FAIL mid_stalled: got v=%b ch=%0d pos=%b, expected v=1 ch=0 pos=0",
               evt_valid, evt_ch, evt_pos);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (evt_valid !== 1'b0 || ovf !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset: got v=%b ovf=%b, expected v=0 ovf=0000", evt_valid, ovf);
    end
    evt_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_no_events cycle %0d: got evt_valid=%b, expected 0", c, evt_valid);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    sig_in    = 4'b0101;
    pos_en    = 4'b1111;
    neg_en    = 4'b1111;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    test_reset();
    test_latency();
    test_round_robin();
    test_stall_overflow();
    test_enables();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel edge-event controller for level inputs such as keys, sensor strobes and handshake lines.
- Per channel: samples the raw input, detects rising/falling edges with per-channel enables, and queues one pending event per edge type.
- Shares a single event output port between all channels using round-robin arbitration and a valid/ready handshake.
- Feeds a downstream consumer (UART reporter, interrupt logic or FSM) that can absorb only one event per cycle and may stall.

Parameters:
NCH, 4, number of input channels (2..16)
IDW, 2, width of the channel id; must satisfy 2**IDW >= NCH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
sig_in  input  NCH  raw level inputs, already synchronous to clk
pos_en  input  NCH  per-channel rising-edge detect enable
neg_en  input  NCH  per-channel falling-edge detect enable
evt_valid  output  1  event present on evt_ch/evt_pos
evt_ready  input  1  consumer accepts the event when high with evt_valid
evt_ch  output  IDW  channel index of the presented event
evt_pos  output  1  1 = rising edge, 0 = falling edge
ovf  output  NCH  sticky per-channel overflow (an edge was lost)
ovf_clr  input  1  clears all ovf bits

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - evt_valid, evt_ch, evt_pos and ovf = 0.
  - All pending bits and order bits = 0.
  - Round-robin pointer = 0.
  - Both sample registers s1[i] and s2[i] load the current sig_in[i], so no edge is reported on reset release.
- Sampling: each cycle s1 <= sig_in and s2 <= s1.
- Edge detection:
  - rise[i] = s1 & ~s2 & pos_en[i].
  - fall[i] = ~s1 & s2 & neg_en[i].
- Pending:
  - rise[i] sets pp[i]; fall[i] sets pn[i].
  - When a detection finds the opposite bit already set, order bit old[i] records which type is older.
- Overflow and load interaction:
  - New edge while the same-type pending bit is set and not being loaded this cycle: ovf[i] <= 1; the pending bit stays 1 (the event is merged).
  - New edge in the same cycle its pending bit is loaded: the bit stays set; no overflow.
- Overflow clear: ovf_clr clears all ovf bits. If an ovf set and ovf_clr occur in the same cycle, the set wins.
- Output register load condition: load when !evt_valid, or when evt_valid && evt_ready.
- Channel selection:
  - Select the first channel with pp|pn set, searching ptr, ptr+1, ... modulo NCH.
  - In the selected channel: if both bits are set, take the older one (per old[i]); otherwise take the set bit.
- On load:
  - Drive evt_valid=1, evt_ch and evt_pos.
  - Clear the chosen pending bit.
  - ptr <= chosen channel + 1 (mod NCH).
- If nothing is pending at a load opportunity, evt_valid <= 0.
- Stall: while evt_valid && !evt_ready, evt_ch and evt_pos are held stable and pending keeps accumulating.
- Throughput and latency:
  - Throughput is one event per cycle when evt_ready is held high.
  - With sig_in changing just before clock edge k, s1 updates at k and pending is set at k+1.
  - With the port idle, evt_valid is high after edge k+2 (3-cycle latency).
- Enables:
  - Deasserting an enable suppresses only new detections.
  - Already-pending events are still delivered.
- Reset mid-operation discards all pending events, the presented event and ovf; no edge is produced on reset release.

Test Plan:
1. Reset with sig_in=4'b0101, release, hold inputs -> evt_valid stays 0 for 20 cycles; ovf=0.
2. Ch2 rises with evt_ready=1 -> evt_valid=1 with evt_ch=2, evt_pos=1 exactly 3 cycles later, for 1 cycle; then ch2 falls -> evt_ch=2, evt_pos=0.
3. All 4 channels rise in the same cycle, evt_ready=1, ptr=0:
   - Events arrive on consecutive cycles in order ch0, ch1, ch2, ch3.
   - A second simultaneous burst is then served starting at ch0 (ptr wrapped).
4. evt_ready=0, ch1 rises, then ch1 falls 2 cycles later, ch1 rises again:
   - ovf[1]=1.
   - After evt_ready=1 the sequence is rise, then fall (older first); no third event.
   - A subsequent ovf_clr pulse -> ovf=0.
5. pos_en[3]=0, neg_en[3]=1, ch3 toggles 0->1->0 -> only one event (ch3, evt_pos=0).
6. 2 events pending, evt_valid=1 stalled, assert rst for 1 cycle -> evt_valid=0 next cycle and no events after release.
